// File: rtl/seq_stage_controller.sv
// seq_stage_controller
// Multi-cycle sequencer for the SEQ Y86-64 datapath. Walks every instruction
// through FETCH, DECODE, EXECUTE, MEMORY (memory-class only), WRITEBACK and
// PCUPD with one-hot stage enables. It owns the ZF/SF/OF condition codes,
// evaluates cmovXX/jXX conditions, runs the data-memory handshake with a
// timeout, and tracks halt/fault status and the retired-instruction count.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin/restart execution (ignored while busy)
//   icode, ifun          fetched instruction, sampled in FETCH
//   instr_valid          fetch unit saw a well-formed instruction
//   imem_error           instruction memory address error
//   alu_zf/sf/of         ALU flags, captured in EXECUTE for OPq
//   mem_req / mem_ack    data-memory handshake; dmem_error sampled with ack
//   en_*                 one-hot stage enables
//   cc                   {ZF,SF,OF}
//   cnd                  condition result for the latched instruction
//   stat                 1=AOK 2=HLT 3=ADR 4=INS
//   busy                 sequencer is stepping an instruction
//   instr_count          retired instructions (wraps)

module seq_stage_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             en_pc,
    output logic [2:0]       cc,
    output logic             cnd,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TMO_W = 8;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXECUTE   = 4'd3;
    localparam logic [3:0] S_MEMORY    = 4'd4;
    localparam logic [3:0] S_WRITEBACK = 4'd5;
    localparam logic [3:0] S_PCUPD     = 4'd6;
    localparam logic [3:0] S_HALTED    = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [2:0] CC_RESET = 3'b100;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_CMOV = 4'h2;
    localparam logic [3:0] IC_OPQ  = 4'h6;
    localparam logic [3:0] IC_JXX  = 4'h7;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state, state_nxt;
    logic [3:0]       icode_q, icode_nxt;
    logic [3:0]       ifun_q, ifun_nxt;
    logic [2:0]       cc_nxt;
    logic [2:0]       stat_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

    logic             bad_instr_c;
    logic             is_mem_c;
    logic             lt_c;
    logic             cond_raw_c;

    // Illegal-instruction decode on the live fetch inputs.
    always_comb begin
        bad_instr_c = 1'b0;
        if (!instr_valid || (icode > 4'd11)) begin
            bad_instr_c = 1'b1;
        end else if (((icode == IC_CMOV) || (icode == IC_JXX)) && (ifun > 4'd6)) begin
            bad_instr_c = 1'b1;
        end else if ((icode == IC_OPQ) && (ifun > 4'd3)) begin
            bad_instr_c = 1'b1;
        end
    end

    // Memory-class instructions: rmmovq, mrmovq, call, ret, pushq, popq.
    always_comb begin
        is_mem_c = 1'b0;
        case (icode_q)
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: is_mem_c = 1'b1;
            default:                               is_mem_c = 1'b0;
        endcase
    end

    // Condition evaluation from the architectural flags and latched ifun.
    always_comb begin
        lt_c       = cc[1] ^ cc[0];
        cond_raw_c = 1'b0;
        case (ifun_q)
            4'd0:    cond_raw_c = 1'b1;
            4'd1:    cond_raw_c = lt_c | cc[2];
            4'd2:    cond_raw_c = lt_c;
            4'd3:    cond_raw_c = cc[2];
            4'd4:    cond_raw_c = ~cc[2];
            4'd5:    cond_raw_c = ~lt_c;
            4'd6:    cond_raw_c = ~lt_c & ~cc[2];
            default: cond_raw_c = 1'b0;
        endcase
        cnd = ((icode_q == IC_CMOV) || (icode_q == IC_JXX)) ? cond_raw_c : 1'b0;
    end

    // Next-state and architectural-state update.
    always_comb begin
        state_nxt = state;
        icode_nxt = icode_q;
        ifun_nxt  = ifun_q;
        cc_nxt    = cc;
        stat_nxt  = stat;
        count_nxt = instr_count;
        tmo_nxt   = '0;

        case (state)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    stat_nxt  = STAT_AOK;
                    cc_nxt    = CC_RESET;
                    count_nxt = '0;
                end
            end
            S_FETCH: begin
                icode_nxt = icode;
                ifun_nxt  = ifun;
                if (imem_error) begin
                    state_nxt = S_FAULT;
                    stat_nxt  = STAT_ADR;
                end else if (bad_instr_c) begin
                    state_nxt = S_FAULT;
                    stat_nxt  = STAT_INS;
                end else if (icode == IC_HALT) begin
                    // halt retires, so it is counted
                    state_nxt = S_HALTED;
                    stat_nxt  = STAT_HLT;
                    count_nxt = instr_count + CNT_W'(1);
                end else begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (icode_q == IC_OPQ) begin
                    cc_nxt = {alu_zf, alu_sf, alu_of};
                end
                state_nxt = is_mem_c ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                // an ack in the final allowed cycle still completes normally
                if (mem_ack) begin
                    if (dmem_error) begin
                        state_nxt = S_FAULT;
                        stat_nxt  = STAT_ADR;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_FAULT;
                    stat_nxt  = STAT_ADR;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            S_WRITEBACK: begin
                state_nxt = S_PCUPD;
            end
            S_PCUPD: begin
                count_nxt = instr_count + CNT_W'(1);
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Architectural registers and latched instruction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q     <= 4'd0;
            ifun_q      <= 4'd0;
            cc          <= CC_RESET;
            stat        <= STAT_AOK;
            instr_count <= '0;
            tmo_cnt     <= '0;
        end else begin
            icode_q     <= icode_nxt;
            ifun_q      <= ifun_nxt;
            cc          <= cc_nxt;
            stat        <= stat_nxt;
            instr_count <= count_nxt;
            tmo_cnt     <= tmo_nxt;
        end
    end

    // Registered stage enables, handshake and busy, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_fetch     <= 1'b0;
            en_decode    <= 1'b0;
            en_execute   <= 1'b0;
            en_memory    <= 1'b0;
            en_writeback <= 1'b0;
            en_pc        <= 1'b0;
            mem_req      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            en_fetch     <= (state_nxt == S_FETCH);
            en_decode    <= (state_nxt == S_DECODE);
            en_execute   <= (state_nxt == S_EXECUTE);
            en_memory    <= (state_nxt == S_MEMORY);
            en_writeback <= (state_nxt == S_WRITEBACK);
            en_pc        <= (state_nxt == S_PCUPD);
            mem_req      <= (state_nxt == S_MEMORY);
            busy         <= !((state_nxt == S_IDLE) || (state_nxt == S_HALTED) ||
                              (state_nxt == S_FAULT));
        end
    end

endmodule
